// File: rtl/sb_packet_rx.sv
// Snoop-bus packet receiver: deframes the byte-serial stream (Start, Type,
// Size, Data MSB-first, Error, End), checks both delimiters, aborts frames on
// an inter-byte timeout and hands good packets to a one-entry valid/ready buffer.
module sb_packet_rx #(
    parameter logic [7:0] START_BYTE = 8'hA5,
    parameter logic [7:0] END_BYTE   = 8'h5A,
    parameter int         TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [7:0]  pkt_type,
    output logic [7:0]  pkt_size,
    output logic [31:0] pkt_data,
    output logic [7:0]  pkt_error,
    output logic [7:0]  pkt_index,
    output logic [15:0] pkt_page,
    output logic        frame_err,
    output logic        overflow
);

    // Count value seen on the idle cycle that completes the timeout window
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TYPE,
        S_SIZE,
        S_D3,
        S_D2,
        S_D1,
        S_D0,
        S_ERR,
        S_END
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  idle_count;
    logic [7:0]  idle_count_next;
    logic [7:0]  asm_type;
    logic [7:0]  asm_size;
    logic [31:0] asm_data;
    logic [7:0]  asm_error;
    logic        good_frame;
    logic        abort_frame;
    logic        buffer_drain;

    assign buffer_drain = pkt_valid && pkt_ready;
    assign pkt_index    = pkt_data[7:0];
    assign pkt_page     = pkt_data[23:8];

    // State and inter-byte idle counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idle_count <= '0;
        end else begin
            state      <= state_next;
            idle_count <= idle_count_next;
        end
    end

    // Next-state decode: one step per valid byte, delimiter checks, timeout abort
    always_comb begin
        state_next      = state;
        idle_count_next = idle_count;
        good_frame      = 1'b0;
        abort_frame     = 1'b0;
        if (state == S_IDLE) begin
            idle_count_next = '0;
            if (rx_valid && (rx_byte == START_BYTE)) begin
                state_next = S_TYPE;
            end
        end else if (rx_valid) begin
            idle_count_next = '0;
            case (state)
                S_TYPE:  state_next = S_SIZE;
                S_SIZE:  state_next = S_D3;
                S_D3:    state_next = S_D2;
                S_D2:    state_next = S_D1;
                S_D1:    state_next = S_D0;
                S_D0:    state_next = S_ERR;
                S_ERR:   state_next = S_END;
                S_END: begin
                    state_next = S_IDLE;
                    if (rx_byte == END_BYTE) begin
                        good_frame = 1'b1;
                    end else begin
                        abort_frame = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else begin
            if (idle_count == TIMEOUT_LAST) begin
                abort_frame     = 1'b1;
                state_next      = S_IDLE;
                idle_count_next = '0;
            end else if (idle_count != 8'hFF) begin
                idle_count_next = idle_count + 8'd1;
            end
        end
    end

    // Assembly register: latch each payload byte as its state consumes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_type  <= '0;
            asm_size  <= '0;
            asm_data  <= '0;
            asm_error <= '0;
        end else if (rx_valid) begin
            case (state)
                S_TYPE:  asm_type         <= rx_byte;
                S_SIZE:  asm_size         <= rx_byte;
                S_D3:    asm_data[31:24]  <= rx_byte;
                S_D2:    asm_data[23:16]  <= rx_byte;
                S_D1:    asm_data[15:8]   <= rx_byte;
                S_D0:    asm_data[7:0]    <= rx_byte;
                S_ERR:   asm_error        <= rx_byte;
                default: ;
            endcase
        end
    end

    // One-entry output buffer: load on a good frame unless full and not draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid <= 1'b0;
            pkt_type  <= '0;
            pkt_size  <= '0;
            pkt_data  <= '0;
            pkt_error <= '0;
        end else if (good_frame && (!pkt_valid || buffer_drain)) begin
            pkt_valid <= 1'b1;
            pkt_type  <= asm_type;
            pkt_size  <= asm_size;
            pkt_data  <= asm_data;
            pkt_error <= asm_error;
        end else if (buffer_drain) begin
            pkt_valid <= 1'b0;
        end
    end

    // Registered single-cycle event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= abort_frame;
            overflow  <= good_frame && pkt_valid && !pkt_ready;
        end
    end

endmodule

// File: tb/tb_sb_packet_rx.sv
// Testbench for sb_packet_rx: directed scenarios with literal expectations,
// then randomized byte streams compared every cycle against a frame-level model.
module tb_sb_packet_rx;

    localparam logic [7:0] START_BYTE = 8'hA5;
    localparam logic [7:0] END_BYTE   = 8'h5A;
    localparam int         TIMEOUT    = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_type;
    logic [7:0]  pkt_size;
    logic [31:0] pkt_data;
    logic [7:0]  pkt_error;
    logic [7:0]  pkt_index;
    logic [15:0] pkt_page;
    logic        frame_err;
    logic        overflow;

    int  check_count = 0;
    int  pass_count  = 0;
    bit  rand_ready  = 1'b0;

    sb_packet_rx #(
        .START_BYTE(START_BYTE),
        .END_BYTE  (END_BYTE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_type (pkt_type),
        .pkt_size (pkt_size),
        .pkt_data (pkt_data),
        .pkt_error(pkt_error),
        .pkt_index(pkt_index),
        .pkt_page (pkt_page),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        if (rand_ready) pkt_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            if (rand_ready) pkt_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
    endtask

    task automatic sendFrame(input logic [7:0] t, input logic [7:0] s, input logic [31:0] d,
                             input logic [7:0] e, input logic [7:0] endb, input int gap_after_size);
        applyStimulus(START_BYTE);
        applyStimulus(t);
        applyStimulus(s);
        idleCycles(gap_after_size);
        applyStimulus(d[31:24]);
        applyStimulus(d[23:16]);
        applyStimulus(d[15:8]);
        applyStimulus(d[7:0]);
        applyStimulus(e);
        applyStimulus(endb);
    endtask

    // Frame-level reference model: collects bytes of the current frame in a
    // queue, judges the frame once nine bytes are present, and counts gaps.
    logic [7:0]  mq[$];
    logic [7:0]  frm[0:8];
    int          gap;
    logic        m_valid;
    logic [7:0]  m_type;
    logic [7:0]  m_size;
    logic [31:0] m_data;
    logic [7:0]  m_err;
    logic [7:0]  m_index;
    logic [15:0] m_page;
    logic        m_fe;
    logic        m_ov;
    logic        s_v;
    logic [7:0]  s_b;
    logic        s_rdy;
    logic        m_good;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                gap     = 0;
                m_valid = 1'b0;
                m_type  = '0;
                m_size  = '0;
                m_data  = '0;
                m_err   = '0;
                m_index = '0;
                m_page  = '0;
                m_fe    = 1'b0;
                m_ov    = 1'b0;
            end else begin
                s_v    = rx_valid;
                s_b    = rx_byte;
                s_rdy  = pkt_ready;
                m_good = 1'b0;
                m_fe   = 1'b0;
                m_ov   = 1'b0;
                if (s_v) begin
                    gap = 0;
                    if (mq.size() == 0) begin
                        if (s_b == START_BYTE) mq.push_back(s_b);
                    end else begin
                        mq.push_back(s_b);
                        if (mq.size() == 9) begin
                            for (int i = 0; i < 9; i++) frm[i] = mq[i];
                            if (s_b == END_BYTE) m_good = 1'b1;
                            else                 m_fe   = 1'b1;
                            mq.delete();
                        end
                    end
                end else if (mq.size() != 0) begin
                    gap++;
                    if (gap == TIMEOUT) begin
                        m_fe = 1'b1;
                        mq.delete();
                        gap = 0;
                    end
                end
                if (m_good) begin
                    if (!m_valid || s_rdy) begin
                        m_valid = 1'b1;
                        m_type  = frm[1];
                        m_size  = frm[2];
                        m_data  = {frm[3], frm[4], frm[5], frm[6]};
                        m_index = frm[6];
                        m_page  = {frm[4], frm[5]};
                        m_err   = frm[7];
                    end else begin
                        m_ov = 1'b1;
                    end
                end else if (m_valid && s_rdy) begin
                    m_valid = 1'b0;
                end
            end
            #1;
            checkOutput("pkt_valid", 32'(pkt_valid), 32'(m_valid));
            checkOutput("pkt_type",  32'(pkt_type),  32'(m_type));
            checkOutput("pkt_size",  32'(pkt_size),  32'(m_size));
            checkOutput("pkt_data",  pkt_data,       m_data);
            checkOutput("pkt_error", 32'(pkt_error), 32'(m_err));
            checkOutput("pkt_index", 32'(pkt_index), 32'(m_index));
            checkOutput("pkt_page",  32'(pkt_page),  32'(m_page));
            checkOutput("frame_err", 32'(frame_err), 32'(m_fe));
            checkOutput("overflow",  32'(overflow),  32'(m_ov));
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [7:0]  r_type;
        logic [7:0]  r_size;
        logic [31:0] r_data;
        logic [7:0]  r_err;
        logic [7:0]  r_end;
        logic [7:0]  bytes[0:8];
        int          kind;

        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        pkt_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset pkt_valid", 32'(pkt_valid), 32'h0);
        checkOutput("reset pkt_data", pkt_data, 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        idleCycles(2);

        // Single good frame
        pkt_ready = 1'b1;
        sendFrame(8'h05, 8'h02, 32'h12345678, 8'h00, 8'h5A, 0);
        checkOutput("t1 pkt_valid", 32'(pkt_valid), 32'h1);
        checkOutput("t1 pkt_type", 32'(pkt_type), 32'h05);
        checkOutput("t1 pkt_size", 32'(pkt_size), 32'h02);
        checkOutput("t1 pkt_data", pkt_data, 32'h12345678);
        checkOutput("t1 pkt_index", 32'(pkt_index), 32'h78);
        checkOutput("t1 pkt_page", 32'(pkt_page), 32'h3456);
        checkOutput("t1 pkt_error", 32'(pkt_error), 32'h00);
        idleCycles(2);

        // Bad End byte, then a good frame with nonzero Error byte
        sendFrame(8'h07, 8'h01, 32'hDEADBEEF, 8'h00, 8'h5B, 0);
        checkOutput("t2 frame_err", 32'(frame_err), 32'h1);
        checkOutput("t2 pkt_valid", 32'(pkt_valid), 32'h0);
        idleCycles(1);
        checkOutput("t2 frame_err drop", 32'(frame_err), 32'h0);
        sendFrame(8'h09, 8'h04, 32'hCAFEF00D, 8'h3C, 8'h5A, 0);
        checkOutput("t2 pkt_data", pkt_data, 32'hCAFEF00D);
        checkOutput("t2 pkt_error", 32'(pkt_error), 32'h3C);
        checkOutput("t2 frame_err after good", 32'(frame_err), 32'h0);
        idleCycles(2);

        // Overflow with consumer stalled
        pkt_ready = 1'b0;
        sendFrame(8'h01, 8'h01, 32'h11112222, 8'h00, 8'h5A, 0);
        checkOutput("t3 first held", 32'(pkt_valid), 32'h1);
        sendFrame(8'h02, 8'h02, 32'h33334444, 8'h00, 8'h5A, 0);
        checkOutput("t3 overflow", 32'(overflow), 32'h1);
        checkOutput("t3 data kept", pkt_data, 32'h11112222);
        idleCycles(1);
        checkOutput("t3 overflow drop", 32'(overflow), 32'h0);
        pkt_ready = 1'b1;
        idleCycles(1);
        checkOutput("t3 drained", 32'(pkt_valid), 32'h0);

        // Timeout after the Size byte
        applyStimulus(START_BYTE);
        applyStimulus(8'h05);
        applyStimulus(8'h02);
        idleCycles(TIMEOUT - 1);
        checkOutput("t4 no early abort", 32'(frame_err), 32'h0);
        idleCycles(1);
        checkOutput("t4 timeout abort", 32'(frame_err), 32'h1);
        idleCycles(2);
        sendFrame(8'h05, 8'h02, 32'hA1B2C3D4, 8'h00, 8'h5A, TIMEOUT - 1);
        checkOutput("t4 gap frame valid", 32'(pkt_valid), 32'h1);
        checkOutput("t4 gap frame data", pkt_data, 32'hA1B2C3D4);
        idleCycles(2);

        // Garbage before Start
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h5A);
        checkOutput("t5 garbage no err", 32'(frame_err), 32'h0);
        sendFrame(8'h0C, 8'h08, 32'h0BADF00D, 8'h00, 8'h5A, 0);
        checkOutput("t5 pkt_type", 32'(pkt_type), 32'h0C);
        checkOutput("t5 pkt_data", pkt_data, 32'h0BADF00D);

        // Reset asserted mid-frame while a packet is held
        pkt_ready = 1'b0;
        idleCycles(2);
        sendFrame(8'h0E, 8'h03, 32'h55667788, 8'h00, 8'h5A, 0);
        applyStimulus(START_BYTE);
        applyStimulus(8'h05);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async pkt_valid", 32'(pkt_valid), 32'h0);
        checkOutput("t6 async pkt_data", pkt_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        pkt_ready = 1'b1;
        sendFrame(8'h0F, 8'h06, 32'h89ABCDEF, 8'h00, 8'h5A, 0);
        checkOutput("t6 post reset data", pkt_data, 32'h89ABCDEF);
        checkOutput("t6 post reset type", 32'(pkt_type), 32'h0F);
        idleCycles(2);

        // Randomized traffic
        rand_ready = 1'b1;
        repeat (400) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                applyStimulus(8'($urandom));
            end else if (kind == 1) begin
                idleCycles($urandom_range(1, 18));
            end else begin
                r_type = 8'($urandom);
                r_size = 8'($urandom);
                r_data = $urandom;
                r_err  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                r_end  = END_BYTE;
                if ($urandom_range(0, 7) == 0) begin
                    r_end = 8'($urandom);
                    if (r_end == END_BYTE) r_end = 8'h00;
                end
                bytes[0] = START_BYTE;
                bytes[1] = r_type;
                bytes[2] = r_size;
                bytes[3] = r_data[31:24];
                bytes[4] = r_data[23:16];
                bytes[5] = r_data[15:8];
                bytes[6] = r_data[7:0];
                bytes[7] = r_err;
                bytes[8] = r_end;
                for (int i = 0; i < 9; i++) begin
                    if ((i > 0) && ($urandom_range(0, 15) == 0)) begin
                        idleCycles($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
                    end
                    applyStimulus(bytes[i]);
                end
            end
        end

        rand_ready = 1'b0;
        pkt_ready  = 1'b1;
        idleCycles(3);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
